// File: rtl/ll_link_server_if.sv
// Handshake bundle between the link clients (ports) and the link-list server.
interface ll_link_server_if #(
  parameter int lpsz  = 8,
  parameter int lpdsz = lpsz + 1
);
  logic              rlp_srdy;
  logic              rlp_drdy;
  logic [lpsz-1:0]   rlp_rd_page;
  logic              rlpr_srdy;
  logic              rlpr_drdy;
  logic [lpdsz-1:0]  rlpr_data;
  logic              drf_srdy;
  logic              drf_drdy;
  logic [2*lpsz-1:0] drf_page_list;
  logic              lnk_srdy;
  logic              lnk_drdy;
  logic [lpsz-1:0]   lnk_page;
  logic [lpdsz-1:0]  lnk_next;
  logic              par_srdy;
  logic              par_drdy;
  logic [lpsz-1:0]   par_page;

  modport master (
    output rlp_srdy, rlp_rd_page, rlpr_drdy, drf_srdy, drf_page_list,
           lnk_srdy, lnk_page, lnk_next, par_drdy,
    input  rlp_drdy, rlpr_srdy, rlpr_data, drf_drdy, lnk_drdy, par_srdy, par_page
  );

  modport slave (
    input  rlp_srdy, rlp_rd_page, rlpr_drdy, drf_srdy, drf_page_list,
           lnk_srdy, lnk_page, lnk_next, par_drdy,
    output rlp_drdy, rlpr_srdy, rlpr_data, drf_drdy, lnk_drdy, par_srdy, par_page
  );
endinterface

// File: rtl/ll_link_server.sv
// Link-list manager: owns the page link memory and the free list.
// Read port serves link lookups and free-list pops; write port serves
// reclaimed-chain splices and per-page link writes.
//
// state  | meaning
// S_INIT | walking the memory, building the initial free list 0..N-1
// S_RUN  | serving rlp/drf/lnk traffic and allocating pages on par
module ll_link_server #(
  parameter int lpsz  = 8,
  parameter int lpdsz = lpsz + 1
) (
  input logic clk,
  input logic reset,
  ll_link_server_if.slave bus
);
  localparam int npages = 2 ** lpsz;
  localparam logic [lpdsz-1:0] stop_page = {1'b1, {(lpdsz-1){1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [lpsz-1:0]  init_cnt;
  logic [lpdsz-1:0] head;
  logic [lpsz-1:0]  tail;        // only meaningful while the list is non-empty
  logic             pop_pend;
  logic [lpdsz-1:0] pop_link;
  logic [lpdsz-1:0] link_mem [npages];

  logic             run;
  logic             list_empty;
  logic             rlp_acc;
  logic             pop_fire;
  logic             drf_acc;
  logic             lnk_acc;
  logic [lpsz-1:0]  rd_addr;
  logic [lpdsz-1:0] rd_word;
  logic             wr_en;
  logic [lpsz-1:0]  wr_addr;
  logic [lpdsz-1:0] wr_data;
  logic [lpsz-1:0]  drf_start;
  logic [lpsz-1:0]  drf_end;

  assign run        = (state == S_RUN);
  assign list_empty = head[lpdsz-1];
  assign drf_start  = bus.drf_page_list[2*lpsz-1:lpsz];
  assign drf_end    = bus.drf_page_list[lpsz-1:0];

  // Read port: rlp wins; a pop only uses the port when rlp leaves it idle.
  assign bus.rlp_drdy = run && (!bus.rlpr_srdy || bus.rlpr_drdy);
  assign rlp_acc      = bus.rlp_srdy && bus.rlp_drdy;
  assign pop_fire     = run && (!bus.par_srdy || bus.par_drdy) && !list_empty
                        && !pop_pend && !rlp_acc;

  // Write port: a splice must not race a pop, otherwise head==tail could be
  // overwritten by the stale link returned for the popped page.
  assign bus.drf_drdy = run && !pop_pend && !pop_fire;
  assign drf_acc      = bus.drf_srdy && bus.drf_drdy;
  assign bus.lnk_drdy = run && !drf_acc;
  assign lnk_acc      = bus.lnk_srdy && bus.lnk_drdy;

  assign rd_addr = rlp_acc ? bus.rlp_rd_page : head[lpsz-1:0];
  assign rd_word = link_mem[rd_addr];

  // Select the single memory write of this cycle: init fill, splice, or link write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == S_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt;
      wr_data = (&init_cnt) ? stop_page : (lpdsz'(init_cnt) + lpdsz'(1));
    end else if (drf_acc) begin
      wr_en   = !list_empty;
      wr_addr = tail;
      wr_data = {1'b0, drf_start};
    end else if (lnk_acc) begin
      wr_en   = 1'b1;
      wr_addr = bus.lnk_page;
      wr_data = bus.lnk_next;
    end
  end

  // Link memory write; reads are captured by the control registers below.
  always_ff @(posedge clk) begin
    if (wr_en) link_mem[wr_addr] <= wr_data;
  end

  // Control FSM with registered response, allocation and free-list state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      head          <= stop_page;
      tail          <= '0;
      pop_pend      <= 1'b0;
      pop_link      <= '0;
      bus.rlpr_srdy <= 1'b0;
      bus.rlpr_data <= '0;
      bus.par_srdy  <= 1'b0;
      bus.par_page  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            head  <= '0;
            tail  <= lpsz'(npages - 1);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (rlp_acc) begin
            bus.rlpr_srdy <= 1'b1;
            bus.rlpr_data <= rd_word;
          end else if (bus.rlpr_drdy) begin
            bus.rlpr_srdy <= 1'b0;
          end

          if (pop_fire) begin
            bus.par_srdy <= 1'b1;
            bus.par_page <= head[lpsz-1:0];
            pop_pend     <= 1'b1;
            pop_link     <= rd_word;
          end else if (bus.par_drdy) begin
            bus.par_srdy <= 1'b0;
          end

          // Second half of a pop: the fetched link becomes the new head.
          if (pop_pend) begin
            head     <= pop_link;
            pop_pend <= 1'b0;
          end

          if (drf_acc) begin
            tail <= drf_end;
            if (list_empty) head <= {1'b0, drf_start};
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: doc/ll_link_server.md
Name: ll_link_server

Overview:
- Synthesizable link-list manager core that answers port-side link traffic.
- Serves read-link-page requests (rlp/rlpr) from the link memory.
- Accepts reclaimed page lists (drf) and splices them onto the tail of the free list.
- Hands out free pages to input ports (par) and stores per-page next-links written by input ports (lnk).

Parameters:
- lpsz, 8, page number width; page count is 2**lpsz.
- lpdsz, lpsz+1, link data width; MSB set marks end of list (stop_page = {1'b1, {lpdsz-1{1'b0}}}).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rlp_srdy  in  1  read-link request valid
- rlp_drdy  out  1  read-link request accept
- rlp_rd_page  in  lpsz  page whose link is requested
- rlpr_srdy  out  1  read-link response valid
- rlpr_drdy  in  1  read-link response accept
- rlpr_data  out  lpdsz  link of requested page
- drf_srdy  in  1  reclaim valid
- drf_drdy  out  1  reclaim accept
- drf_page_list  in  2*lpsz  {start_page, end_page} of a chain already linked in memory
- lnk_srdy  in  1  link write valid
- lnk_drdy  out  1  link write accept
- lnk_page  in  lpsz  page to write
- lnk_next  in  lpdsz  next-link value (stop_page for last page)
- par_srdy  out  1  allocated page valid
- par_drdy  in  1  allocated page accept
- par_page  out  lpsz  allocated page number

Behaviour:
- Storage: link memory of 2**lpsz x lpdsz, 1R1W, registered read. When read and write hit the same address in the same cycle, the read returns the old data.
- Free list state: head, tail (lpdsz each). Empty when head[lpdsz-1] is set.
- Reset (synchronous, clk edge with reset=1):
  - All srdy/drdy outputs go to 0; rlpr_data and par_page go to 0.
  - FSM enters INIT with counter 0.
- INIT:
  - Writes link[i] = i+1 for i = 0..N-2, one entry per cycle, then link[N-1] = stop_page.
  - On leaving INIT: head = 0, tail = N-1, FSM -> RUN.
  - All drdy outputs and par_srdy stay 0 throughout INIT (N cycles).
  - Reset asserted at any point, in any state, restarts INIT and drops all in-flight responses.
- Read-port arbitration (RUN), one read per cycle: rlp has priority over pop.
- rlp:
  - rlp_drdy = (!rlpr_srdy || rlpr_drdy) in RUN.
  - On acceptance, rlpr_srdy = 1 next cycle with rlpr_data = link[rlp_rd_page].
  - rlpr_srdy and rlpr_data hold until rlpr_drdy.
  - Sustains 1 request/cycle with rlpr_drdy tied high.
- Pop (allocation):
  - Fires when par holding register is empty (or draining this cycle), the list is non-empty, no pop is pending, and rlp is not accepted this cycle.
  - Cycle 0: par_page <= head[lpsz-1:0], par_srdy <= 1, memory read of link[head].
  - Cycle 1: head <= read data. If that data is stop_page, the list becomes empty.
  - At most one pop in flight.
- Write-port arbitration (RUN): drf has priority over lnk; one write per cycle. lnk_drdy = 0 in any cycle drf is accepted.
- drf:
  - drf_drdy = 0 while a pop is pending, to prevent a stale head when head==tail.
  - On acceptance with list non-empty: link[tail] <= {1'b0, start}, tail <= end.
  - On acceptance with list empty: head <= start, tail <= end, no memory write.
  - Chain content between start and end is not touched.
- lnk: on acceptance, link[lnk_page] <= lnk_next. No free-list effect.
- Simultaneous events:
  - rlp + drf + lnk + pop arbitrate independently on the two ports as above.
  - A pop and a drf in the same cycle are impossible by rule.
- The block does not check for double-free or out-of-range chains.

Test Plan:
- Reset 1 cycle, hold par_drdy=0 -> no drdy/par_srdy for 256 cycles. Then par_page=0; accepting pages in sequence yields 0,1,2,...,255 with no gaps, then par_srdy stays 0 (empty).
- After draining all pages: lnk writes link[5]=9, link[9]=stop, then rlp page 5 -> rlpr_data=9 one cycle after accept; rlp page 9 -> 0x100.
- Reclaim {5,9} into empty list -> next two pops give 5, 9, then empty. Reclaim {5,9} then {3,3} (link[3]=stop) -> pops 5, 9, 3.
- rlpr_drdy=0 for 5 cycles with back-to-back rlp -> one response held stable, rlp_drdy=0 until drain, no lost or duplicated responses.
- Single-entry free list (head==tail) with drf_srdy and par_drdy both high -> pop completes first, drf accepted afterwards, list order correct.
- Reset asserted mid-stream (rlpr_srdy=1, pop pending) -> all outputs 0 next cycle, INIT repeats, first pop after INIT is page 0.
